pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline buffer, the successor of the fixed per-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the 32-bit MIPS pipeline.
- Carries one control bundle and one data bundle of configurable widths, with valid/ready flow control.
- Provides stall through backpressure, flush that inserts a bubble, and an optional skid slot so in_ready is registered.
- The ctrl bundle is zeroed for any bubble, so MemWrite, RegWrite and similar signals can never assert on an invalid slot.

Parameters:
- CTRL_W, 6, width of control bundle (WB 2 + M 3 + Jump 1 for the EX/MEM instance).
- DATA_W, 134, width of data bundle (ADD_Res 32 + ZF 1 + ALU_Res 32 + store data 32 + dest reg 5 + jump target 32).
- SKID, 1, 1 = two-entry buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  buffer accepts beat this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- flush  in  1  synchronous kill of all held beats.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_ctrl  out  CTRL_W  control bundle; all zero whenever out_valid=0.
- out_data  out  DATA_W  data bundle.
- occ  out  2  entries held: 0, 1 or 2.

Behaviour:
- Reset (rst_n=0, async):
  - state EMPTY, out_valid=0, out_ctrl=0, out_data=0, occ=0.
  - in_ready=1 once reset is released.
  - Asserting reset mid-operation discards all held beats immediately.
- Handshakes:
  - Accept occurs when in_valid & in_ready; emit occurs when out_valid & out_ready.
  - Latency from accept to out_valid is 1 cycle.
  - Order is strictly FIFO; no beat is duplicated or dropped except by flush.
- Storage:
  - main slot drives out_*; skid slot exists only when SKID=1.
- State machine for SKID=1 (in_ready is a register):
  - EMPTY: out_valid=0, in_ready=1.
    - accept -> ONE, with main<=in.
  - ONE: out_valid=1, in_ready=1.
    - accept & emit -> ONE, with main<=in.
    - accept & !out_ready -> TWO, with skid<=in and in_ready<=0.
    - emit without accept -> EMPTY.
    - neither -> ONE, holding main.
  - TWO: out_valid=1, in_ready=0.
    - emit -> ONE, with main<=skid and in_ready<=1.
    - otherwise hold.
- SKID=0:
  - States EMPTY and ONE only.
  - in_ready = out_ready | ~out_valid (combinational).
  - accept & emit in the same cycle reloads main.
- flush (synchronous, highest priority over every transfer):
  - Next state EMPTY, out_valid=0, out_ctrl=0, skid discarded, in_ready=1, occ=0.
  - A beat offered in the flush cycle is dropped even if in_ready=1.
  - out_data holds its last value (don't care).
- Bubble rule:
  - out_ctrl is forced to 0 in every cycle with out_valid=0, including after an emit to EMPTY.
  - out_data may hold stale data.
- Stall: holding out_ready=0 freezes out_ctrl and out_data bit-exactly for any number of cycles.
- occ is 0 in EMPTY, 1 in ONE, 2 in TWO, registered with the state.
- Widths are pass-through only; no arithmetic. CTRL_W and DATA_W must each be >=1.

Decomposition:
- pipe_pkg holds:
  - CTRL_W/DATA_W constants per stage (IFID, IDEX, EXMEM, MEMWB).
  - EX/MEM field offsets: WB[1:0], M_Branch, M_MemRead, M_MemWrite, Jump, and the data field LSB positions.
  - State encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
- Sub-module pipe_slot: a register of CTRL_W+DATA_W with load enable, and ctrl clear on async reset and flush. Instantiated once for main and once for skid (the latter when SKID=1).

Test Plan:
- Reset: hold rst_n=0, then release -> out_valid=0, out_ctrl=0, occ=0, in_ready=1. Assert rst_n=0 while occ=2 -> outputs clear in the same cycle, without waiting for a clk edge.
- Streaming: SKID=1, in_valid=1 with data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles starting 1 cycle after the first accept; occ stays 1; in_ready stays 1.
- Backpressure: out_ready=0 while sending beats A=0x11 and B=0x22 -> occ=2 and in_ready=0 after B; out_data=0x11 is held 5 cycles. Raise out_ready -> emits 0x11 then 0x22 with no loss and no duplicate.
- Flush: flush=1 with occ=2 while C=0x33 is offered -> next cycle out_valid=0, out_ctrl=6'b0, occ=0, in_ready=1. C never appears at the output.
- Bubble ctrl: send one beat with in_ctrl=6'b111111, then idle, with out_ready=1 -> out_ctrl=6'h3F for exactly 1 cycle, then 6'h00 while out_valid=0.
- SKID=0: with out_ready=0 and occ=1 -> in_ready=0 combinationally. Toggle out_ready every cycle with in_valid=1 -> throughput equals the out_ready duty cycle, in order.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the MIPS inter-stage pipeline buffers.
//   - Per-stage CTRL_W / DATA_W constants (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - EX/MEM control-bit and data-field LSB offsets.
//   - Buffer state encoding and an occupancy helper.
package pipe_pkg;

  // IF/ID carries no control; one spare bit keeps the control width legal.
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;   // PC+4 32 + instruction 32
  localparam int IDEX_CTRL_W  = 10;   // WB 2 + M 3 + EX 4 + Jump 1
  localparam int IDEX_DATA_W  = 170;  // PC+4, rs, rt, imm (4x32) + rt/rd (2x5) + jump target 32
  localparam int EXMEM_CTRL_W = 6;    // WB 2 + M 3 + Jump 1
  localparam int EXMEM_DATA_W = 134;  // ADD_Res, ZF, ALU_Res, store data, dest reg, jump target
  localparam int MEMWB_CTRL_W = 2;    // WB 2
  localparam int MEMWB_DATA_W = 69;   // read data 32 + ALU_Res 32 + dest reg 5

  // EX/MEM control bundle bit positions.
  localparam int EXMEM_WB_LSB      = 0;  // WB[1:0] = {MemtoReg, RegWrite}
  localparam int EXMEM_M_BRANCH    = 2;
  localparam int EXMEM_M_MEMREAD   = 3;
  localparam int EXMEM_M_MEMWRITE  = 4;
  localparam int EXMEM_JUMP        = 5;

  // EX/MEM data bundle field LSB positions.
  localparam int EXMEM_ADD_RES_LSB = 0;    // 32 bits
  localparam int EXMEM_ZF_LSB      = 32;   // 1 bit
  localparam int EXMEM_ALU_RES_LSB = 33;   // 32 bits
  localparam int EXMEM_ST_DATA_LSB = 65;   // 32 bits
  localparam int EXMEM_DEST_LSB    = 97;   // 5 bits
  localparam int EXMEM_JTGT_LSB    = 102;  // 32 bits

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // The encoding equals the number of entries held.
  function automatic logic [1:0] occ_of(input buf_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage entry of a pipeline buffer.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears ctrl and data
//   load     capture d_ctrl/d_data
//   clr_ctrl zero the control bundle (wins over load); data is left alone
//   d_ctrl / d_data   incoming bundles
//   q_ctrl / q_data   stored bundles
module pipe_slot #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 134
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else begin
      if (clr_ctrl)  q_ctrl <= '0;
      else if (load) q_ctrl <= d_ctrl;
      if (load)      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised inter-stage pipeline buffer with valid/ready.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_ctrl/in_data       upstream control and data bundles
//   flush                 synchronous kill of all held beats (highest priority)
//   out_valid/out_ready   downstream handshake
//   out_ctrl/out_data     held bundles; out_ctrl is zero whenever out_valid=0
//   occ                   entries held (0, 1 or 2)
// SKID=1 gives a two-entry buffer with registered in_ready; SKID=0 is a single
// register whose in_ready is combinational from out_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 134,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  buf_state_t state_reg, state_next;

  logic accept, emit;
  logic load_main, load_skid, main_from_skid;
  logic clr_main;

  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // Next-state and slot load decisions.
  always_comb begin
    state_next     = state_reg;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // A beat offered during flush is dropped, even if in_ready was high.
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            load_main  = 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            load_main = 1'b1;
          end else if (accept && (SKID != 0)) begin
            // Downstream stalled: park the new beat behind the current one.
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (emit) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            state_next     = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    out_valid = (state_reg != EMPTY);
    occ       = occ_of(state_reg);
    // Zero the main control whenever the slot is about to become a bubble,
    // so out_ctrl is a clean register output with no gating.
    clr_main  = flush | (state_next == EMPTY);
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_main),
    .clr_ctrl (clr_main),
    .d_ctrl   (main_from_skid ? skid_ctrl : in_ctrl),
    .d_data   (main_from_skid ? skid_data : in_data),
    .q_ctrl   (out_ctrl),
    .q_data   (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_reg;

      // in_ready is a flop: low exactly when the buffer will hold two beats.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready_reg <= 1'b1;
        else        in_ready_reg <= (state_next != TWO);
      end
      assign in_ready = in_ready_reg;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_skid),
        .clr_ctrl (flush),
        .d_ctrl   (in_ctrl),
        .d_data   (in_data),
        .q_ctrl   (skid_ctrl),
        .q_data   (skid_data)
      );
    end else begin : g_noskid
      assign in_ready  = out_ready | ~out_valid;
      assign skid_ctrl = '0;
      assign skid_data = '0;
    end
  endgenerate

endmodule
